mult_div_unit: RTL

- Multi-cycle multiply/divide unit in the execute stage of the pipelined core, next to the combinational ALU.
- Handles MULT/MULTU/DIV/DIVU, which the single-cycle ALU cannot.
- Results go to architectural HI/LO registers, which MFHI/MFLO read directly.
- The hazard unit uses start/busy/done to stall the pipeline while an operation is in flight.

---
 rtl/mult_div_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit writing the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with sign fix-up on completion.
module mult_div_unit #(
    parameter int data_width = 32,
    parameter int cnt_width  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            opSel,
    input  logic [data_width-1:0] operand1,
    input  logic [data_width-1:0] operand2,
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] hi,
    output logic [data_width-1:0] lo,
    output logic                  divByZero
);
    localparam int W = data_width;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t               state;
    logic [cnt_width-1:0] cnt;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 dz;
    logic [W-1:0]         m;
    logic [W-1:0]         acc_hi;
    logic [W-1:0]         acc_lo;

    logic                 accept;
    logic                 sgn;
    logic [W-1:0]         mag1;
    logic [W-1:0]         mag2;
    logic [W:0]           mul_sum;
    logic [W:0]           div_trial;
    logic [2*W-1:0]       prod;
    logic [2*W-1:0]       prod_fix;
    logic [W-1:0]         q_fix;
    logic [W-1:0]         r_fix;

    assign accept = start && (state == IDLE || state == FINISH);
    assign sgn    = ~opSel[0];
    assign mag1   = (sgn && operand1[W-1]) ? -operand1 : operand1;
    assign mag2   = (sgn && operand2[W-1]) ? -operand2 : operand2;

    // m is the multiplicand (multiply) or the divisor (divide)
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    assign div_trial = {acc_hi, acc_lo[W-1]} - {1'b0, m};

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_res ? -prod : prod;
    assign q_fix    = neg_res ? -acc_lo : acc_lo;
    assign r_fix    = neg_rem ? -acc_hi : acc_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            divByZero <= 1'b0;
            is_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            dz        <= 1'b0;
            m         <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
        end else begin
            unique case (state)
                IDLE, FINISH: begin
                    done <= 1'b0;
                    if (accept) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        is_div  <= opSel[1];
                        neg_res <= sgn & (operand1[W-1] ^ operand2[W-1]);
                        neg_rem <= sgn & operand1[W-1];
                        dz      <= opSel[1] & (operand2 == '0);
                        m       <= opSel[1] ? mag2 : mag1;
                        acc_lo  <= opSel[1] ? mag1 : mag2;
                        acc_hi  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt < cnt_width'(W)) begin
                        cnt  <= cnt + cnt_width'(1);
                        busy <= (cnt != cnt_width'(W - 1));
                        if (is_div) begin
                            if (!div_trial[W]) begin
                                acc_hi <= div_trial[W-1:0];
                                acc_lo <= {acc_lo[W-2:0], 1'b1};
                            end else begin
                                acc_hi <= {acc_hi[W-2:0], acc_lo[W-1]};
                                acc_lo <= {acc_lo[W-2:0], 1'b0};
                            end
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[W-1:1]};
                        end
                    end else begin
                        // Sign fix-up cycle: results land in HI/LO here
                        state     <= FINISH;
                        done      <= 1'b1;
                        divByZero <= dz;
                        if (is_div) begin
                            hi <= r_fix;
                            lo <= dz ? '1 : q_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
